// File: rtl/btn_sram_ctrl_multi.sv
// btn_sram_ctrl_multi
// Debounces NUM_KEYS active-low push-buttons and turns presses into pending
// commands. The commands are applied at end-of-frame: scroll the SRAM read base
// up or down by one line (key0/key1), toggle freeze (key2), or sweep-clear the
// frame buffer (key3).
// Ports:
//   pixel_clk    sole clock, rising edge
//   rst          synchronous active-high reset
//   EoFrame      one-cycle end-of-frame strobe
//   key          raw keys, asynchronous, active-low
//   key_pressed  one-cycle pulse per accepted press
//   base_addr    SRAM word address of the first displayed pixel
//   freeze       display path must not accept new UART writes
//   clr_busy     clear sweep owns the SRAM
//   sram_addr    write address during the sweep
//   sram_wdata   write data (always zero)
//   sram_we_n    active-low write enable, low only during the sweep
module btn_sram_ctrl_multi #(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned ADDR_WIDTH      = 20,
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned LINE_WORDS      = 640,
  parameter int unsigned FRAME_WORDS     = 307200
) (
  input  logic                  pixel_clk,
  input  logic                  rst,
  input  logic                  EoFrame,
  input  logic [NUM_KEYS-1:0]   key,
  output logic [NUM_KEYS-1:0]   key_pressed,
  output logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  freeze,
  output logic                  clr_busy,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  output logic                  sram_we_n
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned SUM_W = ADDR_WIDTH + 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  // Key front end
  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [NUM_KEYS-1:0] r_deb;
  logic [NUM_KEYS-1:0] r_deb_d;
  logic [NUM_KEYS-1:0] r_key_pressed;
  logic [CNT_W-1:0]    r_cnt [NUM_KEYS];

  // Command / sweep state
  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_pend;
  logic [3:0]            w_pend_nxt;
  logic [3:0]            w_eff;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] w_base_nxt;
  logic                  r_freeze;
  logic                  w_freeze_nxt;
  logic                  r_busy;
  logic                  w_busy_nxt;
  logic [ADDR_WIDTH-1:0] r_saddr;
  logic [ADDR_WIDTH-1:0] w_saddr_nxt;
  logic                  r_we_n;
  logic                  w_we_n_nxt;

  logic [SUM_W-1:0] w_base_ext;
  logic [SUM_W-1:0] w_up_sum;
  logic [SUM_W-1:0] w_up;
  logic [SUM_W-1:0] w_dn;

  // Synchroniser, debouncer and press-pulse register per key.
  // The deb value is delayed once more so a debounced fall is seen as a
  // registered pulse one cycle after the debounced state moves.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      r_sync1       <= '1;
      r_sync2       <= '1;
      r_deb         <= '1;
      r_deb_d       <= '1;
      r_key_pressed <= '0;
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1       <= key;
      r_sync2       <= r_sync1;
      r_deb_d       <= r_deb;
      r_key_pressed <= r_deb_d & ~r_deb;
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        if (r_sync2[i] != r_deb[i]) begin
          if (r_cnt[i] == CNT_W'(DEBOUNCE_CYCLES)) begin
            r_deb[i] <= r_sync2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // Wrap-around scroll arithmetic, one bit wider than the address
  always_comb begin
    w_base_ext = {1'b0, r_base};
    w_up_sum   = w_base_ext + SUM_W'(LINE_WORDS);
    if (w_up_sum >= SUM_W'(FRAME_WORDS)) begin
      w_up = w_up_sum - SUM_W'(FRAME_WORDS);
    end else begin
      w_up = w_up_sum;
    end
    if (w_base_ext < SUM_W'(LINE_WORDS)) begin
      w_dn = w_base_ext + SUM_W'(FRAME_WORDS) - SUM_W'(LINE_WORDS);
    end else begin
      w_dn = w_base_ext - SUM_W'(LINE_WORDS);
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_base_nxt   = r_base;
    w_freeze_nxt = r_freeze;
    w_busy_nxt   = r_busy;
    w_saddr_nxt  = r_saddr;
    w_we_n_nxt   = r_we_n;
    // A pulse in the same cycle as EoFrame still counts for that frame
    w_eff        = r_pend | r_key_pressed[3:0];
    w_pend_nxt   = w_eff;

    unique case (r_state)
      S_IDLE: begin
        if (EoFrame) begin
          w_pend_nxt = '0;
          if (w_eff[2]) begin
            w_freeze_nxt = ~r_freeze;
          end
          if (w_eff[3]) begin
            // Clear wins over scroll; scroll requests are discarded
            w_state_nxt = S_CLEAR;
            w_busy_nxt  = 1'b1;
            w_saddr_nxt = '0;
            w_we_n_nxt  = 1'b0;
          end else if (w_eff[0] && !w_eff[1]) begin
            w_base_nxt = ADDR_WIDTH'(w_up);
          end else if (w_eff[1] && !w_eff[0]) begin
            w_base_nxt = ADDR_WIDTH'(w_dn);
          end
        end
      end
      S_CLEAR: begin
        // EoFrame ignored; clear requests dropped, others kept pending
        w_pend_nxt = r_pend | {1'b0, r_key_pressed[2:0]};
        if (r_saddr == ADDR_WIDTH'(FRAME_WORDS - 1)) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_we_n_nxt  = 1'b1;
          w_saddr_nxt = '0;
          w_base_nxt  = '0;
        end else begin
          w_saddr_nxt = r_saddr + ADDR_WIDTH'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pend   <= '0;
      r_base   <= '0;
      r_freeze <= 1'b0;
      r_busy   <= 1'b0;
      r_saddr  <= '0;
      r_we_n   <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_pend   <= w_pend_nxt;
      r_base   <= w_base_nxt;
      r_freeze <= w_freeze_nxt;
      r_busy   <= w_busy_nxt;
      r_saddr  <= w_saddr_nxt;
      r_we_n   <= w_we_n_nxt;
    end
  end

  assign key_pressed = r_key_pressed;
  assign base_addr   = r_base;
  assign freeze      = r_freeze;
  assign clr_busy    = r_busy;
  assign sram_addr   = r_saddr;
  assign sram_wdata  = '0;
  assign sram_we_n   = r_we_n;

endmodule
